// File: rtl/cmp_flag_branch.sv
// ---------------------------------------------------------------------------
// cmp_flag_branch
//
// EX-stage consumer of the CMP compare result. Holds the architectural
// 2-bit flag register, evaluates conditional branches against it, and turns
// a taken branch into a registered one-cycle PC redirect plus a matching
// flush of the wrong-path IF/ID instructions. The flags are saved to a
// shadow register on interrupt entry and restored from it on RETI. A
// free-running counter records how many branches were taken.
//
// Parameters
//   CPU_WIDTH   datapath / PC / counter width
//   FWD_EN      1: a branch in the same cycle as a flag write sees cmp_in
//               0: a branch always sees the registered flags
//
// Ports
//   clk          clock, all state updates on the rising edge
//   rst          synchronous active-high reset
//   stall        pipeline stall, freezes flag writes and branch evaluation
//   flag_we      CMP instruction in EX, write cmp_in into the flags
//   cmp_in       2-bit compare result from CMP (EQ / L / G)
//   br_valid     branch instruction in EX
//   br_cond      branch condition (AL EQ NE LT GE GT LE NV)
//   br_target    branch target address
//   int_enter    interrupt accepted, save flags to the shadow register
//   int_return   RETI in EX, restore flags from the shadow register
//   flags_o      current flag register
//   redirect_o   one-cycle pulse, PC must load target_o
//   target_o     redirect address, holds the last taken target
//   flush_o      identical to redirect_o, kills wrong-path IF/ID
//   taken_cnt_o  number of taken branches, wraps modulo 2^CPU_WIDTH
// ---------------------------------------------------------------------------
module cmp_flag_branch #(
    parameter int CPU_WIDTH = 16,
    parameter bit FWD_EN    = 1'b1
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 stall,
    input  logic                 flag_we,
    input  logic [1:0]           cmp_in,
    input  logic                 br_valid,
    input  logic [2:0]           br_cond,
    input  logic [CPU_WIDTH-1:0] br_target,
    input  logic                 int_enter,
    input  logic                 int_return,
    output logic [1:0]           flags_o,
    output logic                 redirect_o,
    output logic [CPU_WIDTH-1:0] target_o,
    output logic                 flush_o,
    output logic [CPU_WIDTH-1:0] taken_cnt_o
);

    // Compare result encodings shared with the CMP unit. 2'b11 is unused
    // by CMP; if it ever arrives it is stored unchanged and matches nothing.
    localparam logic [1:0] CMP_EQ = 2'b00;
    localparam logic [1:0] CMP_L  = 2'b01;
    localparam logic [1:0] CMP_G  = 2'b10;

    typedef enum logic [2:0] {
        COND_AL = 3'b000,
        COND_EQ = 3'b001,
        COND_NE = 3'b010,
        COND_LT = 3'b011,
        COND_GE = 3'b100,
        COND_GT = 3'b101,
        COND_LE = 3'b110,
        COND_NV = 3'b111
    } cond_e;

    logic [1:0]           flags_q;
    logic [1:0]           shadow_q;
    logic                 redirect_q;
    logic [CPU_WIDTH-1:0] target_q;
    logic [CPU_WIDTH-1:0] cnt_q;

    logic                 we_q;
    logic                 bv_q;
    logic [1:0]           flags_next;
    logic [1:0]           eff_flags;
    logic                 is_eq;
    logic                 is_lt;
    logic                 is_gt;
    logic                 cond_true;
    logic                 take;

    // A branch issued right after a redirect is a wrong-path instruction
    // that slipped in before the flush landed, so it is discarded.
    assign we_q = flag_we & ~stall;
    assign bv_q = br_valid & ~stall & ~redirect_q;

    // RETI restore beats a same-cycle CMP write.
    always_comb begin
        flags_next = flags_q;
        if (int_return) begin
            flags_next = shadow_q;
        end else if (we_q) begin
            flags_next = cmp_in;
        end
    end

    // With forwarding a branch paired with a CMP write sees the fresh
    // result instead of the stale register contents.
    assign eff_flags = (FWD_EN && we_q) ? cmp_in : flags_q;

    assign is_eq = (eff_flags == CMP_EQ);
    assign is_lt = (eff_flags == CMP_L);
    assign is_gt = (eff_flags == CMP_G);

    always_comb begin
        cond_true = 1'b0;
        case (cond_e'(br_cond))
            COND_AL: cond_true = 1'b1;
            COND_EQ: cond_true = is_eq;
            COND_NE: cond_true = ~is_eq;
            COND_LT: cond_true = is_lt;
            COND_GE: cond_true = ~is_lt;
            COND_GT: cond_true = is_gt;
            COND_LE: cond_true = ~is_gt;
            COND_NV: cond_true = 1'b0;
            default: cond_true = 1'b0;
        endcase
    end

    assign take = bv_q & cond_true;

    // Shadow captures the post-write flags so an interrupt taken on the
    // same cycle as a CMP does not lose that compare. When entry and return
    // coincide the shadow is left alone.
    always_ff @(posedge clk) begin
        if (rst) begin
            flags_q    <= CMP_EQ;
            shadow_q   <= CMP_EQ;
            redirect_q <= 1'b0;
            target_q   <= '0;
            cnt_q      <= '0;
        end else begin
            flags_q <= flags_next;
            if (int_enter && !int_return) begin
                shadow_q <= flags_next;
            end
            redirect_q <= take;
            if (take) begin
                target_q <= br_target;
                cnt_q    <= cnt_q + CPU_WIDTH'(1);
            end
        end
    end

    assign flags_o     = flags_q;
    assign redirect_o  = redirect_q;
    assign flush_o     = redirect_q;
    assign target_o    = target_q;
    assign taken_cnt_o = cnt_q;

endmodule

// File: tb/tb_cmp_flag_branch.sv
// ---------------------------------------------------------------------------
// tb_cmp_flag_branch
//
// Three copies of the block share one stimulus stream:
//   inst0  CPU_WIDTH=16, FWD_EN=1
//   inst1  CPU_WIDTH=16, FWD_EN=0
//   inst2  CPU_WIDTH=8,  FWD_EN=1  (small counter so wrap-around is reachable)
// The driver steps a behavioural model for each instance and queues the
// expected post-edge outputs; a monitor pops one entry per cycle and
// compares every output of every instance.
// ---------------------------------------------------------------------------
module tb_cmp_flag_branch;

    localparam logic [1:0] CMP_EQ = 2'b00;
    localparam logic [1:0] CMP_L  = 2'b01;
    localparam logic [1:0] CMP_G  = 2'b10;

    localparam logic [2:0] C_AL = 3'd0;
    localparam logic [2:0] C_EQ = 3'd1;
    localparam logic [2:0] C_NE = 3'd2;
    localparam logic [2:0] C_LT = 3'd3;
    localparam logic [2:0] C_GE = 3'd4;
    localparam logic [2:0] C_GT = 3'd5;
    localparam logic [2:0] C_LE = 3'd6;
    localparam logic [2:0] C_NV = 3'd7;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst        = 1'b0;
    logic        stall      = 1'b0;
    logic        flag_we    = 1'b0;
    logic [1:0]  cmp_in     = 2'b00;
    logic        br_valid   = 1'b0;
    logic [2:0]  br_cond    = 3'b000;
    logic [15:0] br_target  = 16'h0000;
    logic        int_enter  = 1'b0;
    logic        int_return = 1'b0;

    logic [1:0]  flags0, flags1, flags2;
    logic        red0, red1, red2;
    logic        fl0, fl1, fl2;
    logic [15:0] tgt0, tgt1, cnt0, cnt1;
    logic [7:0]  tgt2, cnt2;

    cmp_flag_branch #(.CPU_WIDTH(16), .FWD_EN(1'b1)) u_dut0 (
        .clk(clk), .rst(rst), .stall(stall), .flag_we(flag_we), .cmp_in(cmp_in),
        .br_valid(br_valid), .br_cond(br_cond), .br_target(br_target),
        .int_enter(int_enter), .int_return(int_return),
        .flags_o(flags0), .redirect_o(red0), .target_o(tgt0), .flush_o(fl0),
        .taken_cnt_o(cnt0)
    );

    cmp_flag_branch #(.CPU_WIDTH(16), .FWD_EN(1'b0)) u_dut1 (
        .clk(clk), .rst(rst), .stall(stall), .flag_we(flag_we), .cmp_in(cmp_in),
        .br_valid(br_valid), .br_cond(br_cond), .br_target(br_target),
        .int_enter(int_enter), .int_return(int_return),
        .flags_o(flags1), .redirect_o(red1), .target_o(tgt1), .flush_o(fl1),
        .taken_cnt_o(cnt1)
    );

    cmp_flag_branch #(.CPU_WIDTH(8), .FWD_EN(1'b1)) u_dut2 (
        .clk(clk), .rst(rst), .stall(stall), .flag_we(flag_we), .cmp_in(cmp_in),
        .br_valid(br_valid), .br_cond(br_cond), .br_target(br_target[7:0]),
        .int_enter(int_enter), .int_return(int_return),
        .flags_o(flags2), .redirect_o(red2), .target_o(tgt2), .flush_o(fl2),
        .taken_cnt_o(cnt2)
    );

    // Reference model state, one slot per instance.
    bit          m_fwd  [3] = '{1'b1, 1'b0, 1'b1};
    logic [15:0] m_mask [3] = '{16'hFFFF, 16'hFFFF, 16'h00FF};
    logic [1:0]  m_flags [3];
    logic [1:0]  m_shadow[3];
    logic        m_red   [3];
    logic [15:0] m_tgt   [3];
    logic [15:0] m_cnt   [3];

    typedef struct packed {
        logic [2:0][1:0]  flags;
        logic [2:0]       red;
        logic [2:0][15:0] tgt;
        logic [2:0][15:0] cnt;
    } exp_t;

    exp_t exp_q[$];

    int checks   = 0;
    int failures = 0;

    // Compare result of an actual signed-free magnitude compare.
    function automatic logic [1:0] cmp_of(input int a, input int b);
        if (a < b) return CMP_L;
        if (a > b) return CMP_G;
        return CMP_EQ;
    endfunction

    // Branch condition rules written out from their meaning.
    function automatic bit cond_holds(input logic [2:0] cond, input logic [1:0] f);
        bit equal, less, greater;
        equal   = (f == CMP_EQ);
        less    = (f == CMP_L);
        greater = (f == CMP_G);
        case (cond)
            C_AL:    return 1'b1;
            C_EQ:    return equal;
            C_NE:    return !equal;
            C_LT:    return less;
            C_GE:    return !less;
            C_GT:    return greater;
            C_LE:    return !greater;
            default: return 1'b0;
        endcase
    endfunction

    task automatic checkOutput(input string name, input int inst,
                               input logic [15:0] act, input logic [15:0] req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("[TB] FAIL %s inst%0d actual=%h required=%h at %0t",
                     name, inst, act, req, $time);
        end
    endtask

    // Drive one cycle of inputs, advance the model and queue expectations.
    task automatic applyStimulus(input logic r, input logic st, input logic we,
                                 input logic [1:0] c, input logic bv,
                                 input logic [2:0] cond, input logic [15:0] tgt,
                                 input logic ie, input logic ir);
        exp_t e;
        @(negedge clk);
        rst        = r;
        stall      = st;
        flag_we    = we;
        cmp_in     = c;
        br_valid   = bv;
        br_cond    = cond;
        br_target  = tgt;
        int_enter  = ie;
        int_return = ir;
        for (int i = 0; i < 3; i++) begin
            if (r) begin
                m_flags[i]  = CMP_EQ;
                m_shadow[i] = CMP_EQ;
                m_red[i]    = 1'b0;
                m_tgt[i]    = 16'h0000;
                m_cnt[i]    = 16'h0000;
            end else begin
                bit wr, br, tk;
                logic [1:0] nf, seen;
                wr   = we && !st;
                br   = bv && !st && !m_red[i];
                nf   = ir ? m_shadow[i] : (wr ? c : m_flags[i]);
                seen = (m_fwd[i] && wr) ? c : m_flags[i];
                tk   = br && cond_holds(cond, seen);
                if (ie && !ir) m_shadow[i] = nf;
                m_flags[i] = nf;
                m_red[i]   = tk;
                if (tk) begin
                    m_tgt[i] = tgt & m_mask[i];
                    m_cnt[i] = (m_cnt[i] + 16'd1) & m_mask[i];
                end
            end
            e.flags[i] = m_flags[i];
            e.red[i]   = m_red[i];
            e.tgt[i]   = m_tgt[i];
            e.cnt[i]   = m_cnt[i];
        end
        exp_q.push_back(e);
    endtask

    task automatic idle(input int n);
        for (int k = 0; k < n; k++)
            applyStimulus(1'b0, 1'b0, 1'b0, 2'b00, 1'b0, C_AL, 16'h0000, 1'b0, 1'b0);
    endtask

    // Monitor: one expected entry per clocked cycle, sampled 1ns after the edge.
    initial begin
        exp_t e;
        logic [2:0][1:0]  a_flags;
        logic [2:0]       a_red, a_fl;
        logic [2:0][15:0] a_tgt, a_cnt;
        forever begin
            @(posedge clk);
            #1;
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                a_flags = {flags2, flags1, flags0};
                a_red   = {red2, red1, red0};
                a_fl    = {fl2, fl1, fl0};
                a_tgt   = {{8'h00, tgt2}, tgt1, tgt0};
                a_cnt   = {{8'h00, cnt2}, cnt1, cnt0};
                for (int i = 0; i < 3; i++) begin
                    checkOutput("flags_o",     i, {14'b0, a_flags[i]}, {14'b0, e.flags[i]});
                    checkOutput("redirect_o",  i, {15'b0, a_red[i]},   {15'b0, e.red[i]});
                    checkOutput("flush_o",     i, {15'b0, a_fl[i]},    {15'b0, e.red[i]});
                    checkOutput("target_o",    i, a_tgt[i],            e.tgt[i]);
                    checkOutput("taken_cnt_o", i, a_cnt[i],            e.cnt[i]);
                end
            end
        end
    end

    initial begin
        // Reset and idle.
        applyStimulus(1'b1, 1'b0, 1'b0, 2'b00, 1'b0, C_AL, 16'h0000, 1'b0, 1'b0);
        applyStimulus(1'b1, 1'b0, 1'b0, 2'b00, 1'b0, C_AL, 16'h0000, 1'b0, 1'b0);
        idle(2);

        // CMP(5,9) then BLT 0x0040.
        applyStimulus(1'b0, 1'b0, 1'b1, cmp_of(5, 9), 1'b0, C_AL, 16'h0000, 1'b0, 1'b0);
        applyStimulus(1'b0, 1'b0, 1'b0, 2'b00, 1'b1, C_LT, 16'h0040, 1'b0, 1'b0);
        idle(2);

        // Flags EQ, then CMP=G and BGT together: forwarded vs registered.
        applyStimulus(1'b0, 1'b0, 1'b1, CMP_EQ, 1'b0, C_AL, 16'h0000, 1'b0, 1'b0);
        applyStimulus(1'b0, 1'b0, 1'b1, CMP_G, 1'b1, C_GT, 16'h0080, 1'b0, 1'b0);
        idle(2);

        // Taken BEQ followed directly by AL: the AL is wrong-path.
        applyStimulus(1'b0, 1'b0, 1'b1, CMP_EQ, 1'b0, C_AL, 16'h0000, 1'b0, 1'b0);
        applyStimulus(1'b0, 1'b0, 1'b0, 2'b00, 1'b1, C_EQ, 16'h0100, 1'b0, 1'b0);
        applyStimulus(1'b0, 1'b0, 1'b0, 2'b00, 1'b1, C_AL, 16'h0200, 1'b0, 1'b0);
        idle(2);

        // Interrupt entry with same-cycle CMP write, overwrite, then RETI.
        applyStimulus(1'b0, 1'b0, 1'b1, CMP_L, 1'b0, C_AL, 16'h0000, 1'b0, 1'b0);
        applyStimulus(1'b0, 1'b0, 1'b1, CMP_G, 1'b0, C_AL, 16'h0000, 1'b1, 1'b0);
        applyStimulus(1'b0, 1'b0, 1'b1, CMP_EQ, 1'b0, C_AL, 16'h0000, 1'b0, 1'b0);
        applyStimulus(1'b0, 1'b0, 1'b0, 2'b00, 1'b0, C_AL, 16'h0000, 1'b0, 1'b1);
        // Entry and return together, while stalled, with a pending write.
        applyStimulus(1'b0, 1'b1, 1'b1, CMP_L, 1'b0, C_AL, 16'h0000, 1'b1, 1'b1);
        applyStimulus(1'b0, 1'b0, 1'b0, 2'b00, 1'b1, C_GT, 16'h0300, 1'b0, 1'b0);
        idle(1);

        // Undefined encoding stored; EQ/LT/GT all false, complements true.
        applyStimulus(1'b0, 1'b0, 1'b1, 2'b11, 1'b0, C_AL, 16'h0000, 1'b0, 1'b0);
        applyStimulus(1'b0, 1'b0, 1'b0, 2'b00, 1'b1, C_EQ, 16'h0400, 1'b0, 1'b0);
        applyStimulus(1'b0, 1'b0, 1'b0, 2'b00, 1'b1, C_LE, 16'h0500, 1'b0, 1'b0);
        idle(1);

        // Reset arriving while a redirect is pending.
        applyStimulus(1'b0, 1'b0, 1'b0, 2'b00, 1'b1, C_AL, 16'h0600, 1'b0, 1'b0);
        applyStimulus(1'b1, 1'b0, 1'b0, 2'b00, 1'b1, C_AL, 16'h0700, 1'b0, 1'b0);
        idle(1);

        // Counter wrap on the 8-bit instance: 256 taken branches.
        for (int k = 0; k < 256; k++) begin
            applyStimulus(1'b0, 1'b0, 1'b0, 2'b00, 1'b1, C_AL, 16'(k), 1'b0, 1'b0);
            idle(1);
        end
        // Stalled AL branch: nothing happens.
        applyStimulus(1'b0, 1'b1, 1'b0, 2'b00, 1'b1, C_AL, 16'hBEEF, 1'b0, 1'b0);
        applyStimulus(1'b0, 1'b1, 1'b1, CMP_G, 1'b1, C_NV, 16'hBEEF, 1'b0, 1'b0);
        idle(2);

        // Randomized traffic.
        for (int k = 0; k < 600; k++) begin
            applyStimulus(($urandom_range(0, 99) == 0),
                          ($urandom_range(0, 4) == 0),
                          ($urandom_range(0, 9) < 4),
                          2'($urandom_range(0, 3)),
                          ($urandom_range(0, 1) == 1),
                          3'($urandom_range(0, 7)),
                          16'($urandom),
                          ($urandom_range(0, 9) == 0),
                          ($urandom_range(0, 9) == 0));
        end
        idle(2);

        repeat (3) @(posedge clk);
        #2;
        checks++;
        if (exp_q.size() != 0) begin
            failures++;
            $display("[TB] FAIL drain actual=%0d required=0", exp_q.size());
        end
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
